// File: rtl/karat_pkg.sv
// Shared width helpers and a wide reference multiply for the pipelined Karatsuba multiplier.
// No logic of its own; imported by the RTL and by the bench.
package karat_pkg;

    localparam int KREF_W = 64;

    function automatic int KH(input int w);
        return w / 2;
    endfunction

    function automatic int KSUMW(input int w);
        return w / 2 + 1;
    endfunction

    function automatic int KZ1W(input int w);
        return w + 2;
    endfunction

    // Plain schoolbook product; callers zero-extend operands and keep the low 2W bits.
    function automatic logic [2*KREF_W-1:0] karat_ref(input logic [KREF_W-1:0] a,
                                                      input logic [KREF_W-1:0] b);
        return (2*KREF_W)'(a) * (2*KREF_W)'(b);
    endfunction

endpackage

// File: rtl/karat_pipe_reg.sv
// Purpose: one valid/ready pipeline register slice carrying an opaque payload.
// Latency: 1 cycle from src handshake to dst_vld.
// Backpressure: src_rdy = !dst_vld || dst_rdy, so a bubble in this slice is always refilled.
module karat_pipe_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          src_vld,
    output logic          src_rdy,
    input  logic [DW-1:0] src_dat,
    output logic          dst_vld,
    input  logic          dst_rdy,
    output logic [DW-1:0] dst_dat
);

    assign src_rdy = !dst_vld || dst_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_vld <= 1'b0;
            dst_dat <= '0;
        end else if (src_rdy) begin
            dst_vld <= src_vld;
            if (src_vld) begin
                dst_dat <= src_dat;
            end
        end
    end

endmodule

// File: rtl/karat_pipe.sv
// Purpose: pipelined one-level Karatsuba W x W unsigned multiplier with a sideband tag.
// Latency: 3 register stages (split/sum, partial products, recombine); 1 op/cycle throughput.
// Backpressure: per-stage valid/ready, bubbles collapse; in_ready depends only on out_ready and stage valids.
module karat_pipe
    import karat_pkg::*;
#(
    parameter int W    = 32,
    parameter int TAGW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    out_p,
    output logic [TAGW-1:0]   out_tag,
    output logic              busy
);

    localparam int H   = KH(W);
    localparam int SW  = KSUMW(W);
    localparam int Z1W = KZ1W(W);
    localparam int PW  = 2*W + 1;

    if (W % 2 != 0 || W < 4) begin : g_bad_width
        $error("karat_pipe: W must be even and at least 4");
    end

    typedef logic [2*H-1:0] zh_t;
    typedef logic [Z1W-1:0] z1_t;
    typedef logic [PW-1:0]  wide_t;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [H-1:0]    al;
        logic [H-1:0]    ah;
        logic [H-1:0]    bl;
        logic [H-1:0]    bh;
        logic [SW-1:0]   sa;
        logic [SW-1:0]   sb;
    } s1_t;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        zh_t             z0;
        zh_t             z2;
        z1_t             z1;
    } s2_t;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [2*W-1:0]  p;
    } s3_t;

    s1_t   s1_d, s1_q;
    s2_t   s2_d, s2_q;
    s3_t   s3_d, s3_q;
    logic  s1_vld, s2_vld, s3_vld;
    logic  s2_rdy, s3_rdy;
    wide_t mid, sum;
    logic  p_carry;

    always_comb begin
        s1_d     = '0;
        s1_d.tag = in_tag;
        s1_d.al  = in_a[H-1:0];
        s1_d.ah  = in_a[W-1:H];
        s1_d.bl  = in_b[H-1:0];
        s1_d.bh  = in_b[W-1:H];
        s1_d.sa  = SW'(in_a[H-1:0]) + SW'(in_a[W-1:H]);
        s1_d.sb  = SW'(in_b[H-1:0]) + SW'(in_b[W-1:H]);
    end

    always_comb begin
        s2_d     = '0;
        s2_d.tag = s1_q.tag;
        s2_d.z0  = zh_t'(s1_q.al) * zh_t'(s1_q.bl);
        s2_d.z2  = zh_t'(s1_q.ah) * zh_t'(s1_q.bh);
        s2_d.z1  = z1_t'(s1_q.sa) * z1_t'(s1_q.sb);
    end

    // mid = z1 - z2 - z0 is never negative, so the wide unsigned subtract is exact.
    always_comb begin
        s3_d     = '0;
        p_carry  = 1'b0;
        mid      = wide_t'(s2_q.z1) - wide_t'(s2_q.z2) - wide_t'(s2_q.z0);
        sum      = (wide_t'(s2_q.z2) << W) + (mid << H) + wide_t'(s2_q.z0);
        s3_d.tag = s2_q.tag;
        {p_carry, s3_d.p} = sum;
    end

    karat_pipe_reg #(.DW($bits(s1_t))) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .src_vld (in_valid),
        .src_rdy (in_ready),
        .src_dat (s1_d),
        .dst_vld (s1_vld),
        .dst_rdy (s2_rdy),
        .dst_dat (s1_q)
    );

    karat_pipe_reg #(.DW($bits(s2_t))) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .src_vld (s1_vld),
        .src_rdy (s2_rdy),
        .src_dat (s2_d),
        .dst_vld (s2_vld),
        .dst_rdy (s3_rdy),
        .dst_dat (s2_q)
    );

    karat_pipe_reg #(.DW($bits(s3_t))) u_s3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .src_vld (s2_vld),
        .src_rdy (s3_rdy),
        .src_dat (s3_d),
        .dst_vld (s3_vld),
        .dst_rdy (out_ready),
        .dst_dat (s3_q)
    );

    assign out_valid = s3_vld;
    assign out_p     = s3_q.p;
    assign out_tag   = s3_q.tag;
    assign busy      = s1_vld || s2_vld || s3_vld;

    // The recombined sum always fits in 2W bits; the dropped top bit must stay zero.
    assert property (@(posedge clk) disable iff (!rst_n) !(s2_vld && p_carry));

endmodule

// File: tb/tb_karat_pipe.sv
// Bench for karat_pipe: a W=32 instance checked every cycle against a queue model, plus a W=16 instance for directed vectors.
module tb_karat_pipe;
    import karat_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v32, r32, ov32, or32, busy32;
    logic [31:0] a32, b32;
    logic [3:0]  t32, ot32;
    logic [63:0] p32;

    logic        v16, r16, ov16, or16, busy16;
    logic [15:0] a16, b16;
    logic [3:0]  t16, ot16;
    logic [31:0] p16;

    karat_pipe #(.W(32), .TAGW(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v32), .in_ready(r32), .in_a(a32), .in_b(b32), .in_tag(t32),
        .out_valid(ov32), .out_ready(or32), .out_p(p32), .out_tag(ot32),
        .busy(busy32)
    );

    karat_pipe #(.W(16), .TAGW(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v16), .in_ready(r16), .in_a(a16), .in_b(b16), .in_tag(t16),
        .out_valid(ov16), .out_ready(or16), .out_p(p16), .out_tag(ot16),
        .busy(busy16)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    endtask

    // Model: every accepted op is owed, in order, 3 cycles after its accept cycle
    // and no sooner than the cycle after its predecessor left.
    typedef struct {
        logic [63:0] p;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    exp_t q[$];
    int cyc      = 0;
    int last_pop = -100;
    int pushes   = 0;
    int pops     = 0;

    always @(negedge clk) begin
        exp_t         e;
        logic [127:0] full;
        logic         exp_ov;
        cyc++;
        if (!rst_n) begin
            q.delete();
            last_pop = -100;
            chk("rst_out_valid", 64'(ov32), 64'd0);
            chk("rst_busy", 64'(busy32), 64'd0);
            chk("rst_out_p", p32, 64'd0);
            chk("rst_out_tag", 64'(ot32), 64'd0);
            chk("rst_in_ready", 64'(r32), 64'd1);
        end else begin
            exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 3) && (cyc >= last_pop + 1);
            chk("out_valid", 64'(ov32), 64'(exp_ov));
            chk("in_ready", 64'(r32), 64'((q.size() < 3) || or32));
            chk("busy", 64'(busy32), 64'(q.size() > 0));
            if (ov32 && q.size() > 0) begin
                chk("out_p", p32, q[0].p);
                chk("out_tag", 64'(ot32), 64'(q[0].tag));
            end
            if (ov32 && or32 && q.size() > 0) begin
                void'(q.pop_front());
                last_pop = cyc;
                pops++;
            end
            if (v32 && r32) begin
                full  = karat_ref(64'(a32), 64'(b32));
                e.p   = full[63:0];
                e.tag = t32;
                e.acc = cyc;
                q.push_back(e);
                pushes++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            assert (dut32.p_carry == 1'b0) else $error("FAIL p_carry32: actual %0b required 0", dut32.p_carry);
            assert (dut16.p_carry == 1'b0) else $error("FAIL p_carry16: actual %0b required 0", dut16.p_carry);
        end
    end

    // One op through an idle pipe with out_ready high; checks latency, product and tag.
    task automatic op(input bit w16, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t, input logic [63:0] exp, input string nm);
        int n;
        bit got;
        @(posedge clk); #1;
        if (w16) begin
            v16 = 1'b1; a16 = a[15:0]; b16 = b[15:0]; t16 = t;
        end else begin
            v32 = 1'b1; a32 = a; b32 = b; t32 = t;
        end
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk); n++;
            got = w16 ? r16 : r32;
        end
        chk({nm, "_accept"}, 64'(got), 64'd1);
        @(posedge clk); #1;
        v16 = 1'b0; v32 = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            got = w16 ? ov16 : ov32;
        end
        chk({nm, "_latency"}, 64'(n), 64'd3);
        chk({nm, "_p"}, w16 ? {32'd0, p16} : p32, exp);
        chk({nm, "_tag"}, 64'(w16 ? ot16 : ot32), 64'(t));
    endtask

    task automatic load_stall_op(input int idx);
        a32 = 32'(100 + idx);
        b32 = 32'(200 + idx);
        t32 = 4'(idx);
    endtask

    initial begin
        int  idx, sent, budget, n;
        bit  fire;

        rst_n = 1'b1;
        v32 = 1'b0; a32 = '0; b32 = '0; t32 = '0; or32 = 1'b1;
        v16 = 1'b0; a16 = '0; b16 = '0; t16 = '0; or16 = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst16_out_valid", 64'(ov16), 64'd0);
        chk("rst16_busy", 64'(busy16), 64'd0);
        chk("rst16_out_p", 64'(p16), 64'd0);
        chk("rst16_in_ready", 64'(r16), 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        op(1'b1, 32'd34, 32'd61, 4'd3, 64'd2074, "w16_small");
        op(1'b1, 32'hFFFF, 32'hFFFF, 4'd5, 64'hFFFE0001, "w16_ones");
        op(1'b1, 32'd0, 32'hBEEF, 4'd7, 64'd0, "w16_zero");
        op(1'b0, 32'd34, 32'd61, 4'd3, 64'd2074, "w32_small");
        op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9, 64'hFFFFFFFE00000001, "w32_ones");
        op(1'b0, 32'd0, 32'h12345678, 4'd2, 64'd0, "w32_zero");
        op(1'b0, 32'h12345678, 32'h9ABCDEF0, 4'd11, 64'h0B00EA4E242D2080, "w32_mixed");

        // Stall: five back-to-back offers with the consumer blocked.
        @(posedge clk); #1;
        or32 = 1'b0; v32 = 1'b1; idx = 0;
        load_stall_op(idx);
        repeat (6) begin
            @(negedge clk); fire = r32;
            @(posedge clk); #1;
            if (fire) begin idx++; load_stall_op(idx); end
        end
        chk("stall_accepted", 64'(idx), 64'd3);
        chk("stall_in_ready", 64'(r32), 64'd0);
        chk("stall_out_valid", 64'(ov32), 64'd1);
        chk("stall_out_p_hold", p32, 64'd20000);
        chk("stall_out_tag_hold", 64'(ot32), 64'd0);
        or32 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); fire = v32 && r32;
            if (k == 0) chk("release_in_ready", 64'(r32), 64'd1);
            chk("drain_valid", 64'(ov32), 64'd1);
            chk("drain_tag", 64'(ot32), 64'(k));
            @(posedge clk); #1;
            if (fire) begin
                idx++;
                if (idx < 5) load_stall_op(idx);
                else v32 = 1'b0;
            end
        end
        chk("stall_all_accepted", 64'(idx), 64'd5);

        // Streaming: random operands, random valid gaps, 50% out_ready.
        sent = 0; budget = 0;
        v32 = 1'b0;
        while (sent < 1000 && budget < 20000) begin
            @(negedge clk); fire = v32 && r32; budget++;
            @(posedge clk); #1;
            or32 = 1'($urandom_range(0, 1));
            if (fire) sent++;
            if (fire || !v32) begin
                v32 = ($urandom_range(0, 3) != 0);
                a32 = $urandom;
                b32 = $urandom;
                t32 = 4'($urandom);
            end
        end
        v32 = 1'b0; or32 = 1'b1;
        n = 0;
        while (busy32 && n < 50) begin @(negedge clk); n++; end
        chk("stream_sent", 64'(sent), 64'd1000);
        chk("stream_drained", 64'(busy32), 64'd0);
        chk("stream_balance", 64'(pops), 64'(pushes));
        chk("stream_model_empty", 64'(q.size()), 64'd0);

        // Reset with two ops in flight.
        @(posedge clk); #1;
        or32 = 1'b0; v32 = 1'b1; a32 = 32'd5; b32 = 32'd6; t32 = 4'd1;
        @(negedge clk);
        @(posedge clk); #1;
        a32 = 32'd8; b32 = 32'd9; t32 = 4'd2;
        @(negedge clk);
        @(posedge clk); #1;
        v32 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_out_valid", 64'(ov32), 64'd1);
        chk("pre_rst_out_p", p32, 64'd30);
        chk("pre_rst_busy", 64'(busy32), 64'd1);
        #1;
        rst_n = 1'b0; v32 = 1'b1; a32 = 32'd3; b32 = 32'd3; t32 = 4'd15;
        #1;
        chk("mid_rst_out_valid", 64'(ov32), 64'd0);
        chk("mid_rst_busy", 64'(busy32), 64'd0);
        chk("mid_rst_out_p", p32, 64'd0);
        chk("mid_rst_out_tag", 64'(ot32), 64'd0);
        chk("mid_rst_in_ready", 64'(r32), 64'd1);
        @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1; v32 = 1'b0; or32 = 1'b1;
        chk("post_rst_busy", 64'(busy32), 64'd0);
        op(1'b0, 32'd7, 32'd9, 4'd6, 64'd63, "post_rst");

        repeat (3) @(negedge clk);
        chk("final_model_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
